// File: rtl/flash_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one flash reader.
// One read is in flight at a time: IDLE -> ISSUE -> WAIT -> DONE, with a WAIT timeout.
module flash_arbiter #(
  parameter int N_REQ   = 4,
  parameter int AW      = 21,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*AW-1:0] i_addr,
  output logic [N_REQ-1:0]    o_ack,
  output logic [DW-1:0]       o_data,
  output logic                o_err,
  output logic                o_busy,
  output logic                o_fl_start,
  output logic [AW-1:0]       o_fl_addr,
  input  logic                i_fl_ack,
  input  logic [DW-1:0]       i_fl_data
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          state_q,   state_d;
  logic [IW-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [IW-1:0]   winner_q,  winner_d;
  logic [TW-1:0]   timer_q,   timer_d;
  logic [AW-1:0]   fl_addr_q, fl_addr_d;
  logic [DW-1:0]   data_q,    data_d;
  logic            err_q,     err_d;

  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic [IW:0]     cand;

  // Search starts at rr_ptr and wraps; the extra bit of cand absorbs rr_ptr+i before wrap.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!grant_found && i_req[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    winner_d  = winner_q;
    timer_d   = timer_q;
    fl_addr_d = fl_addr_q;
    data_d    = data_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          winner_d  = grant_idx;
          fl_addr_d = i_addr[int'(grant_idx)*AW +: AW];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the final WAIT cycle takes priority over the timeout.
        if (i_fl_ack) begin
          data_d  = i_fl_data;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (timer_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        rr_ptr_d = (winner_q == IW'(N_REQ - 1)) ? '0 : winner_q + IW'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      winner_q  <= '0;
      timer_q   <= '0;
      fl_addr_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      winner_q  <= winner_d;
      timer_q   <= timer_d;
      fl_addr_q <= fl_addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    o_ack = '0;
    if (state_q == S_DONE) begin
      o_ack[winner_q] = 1'b1;
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_fl_start = (state_q == S_ISSUE);
  assign o_fl_addr  = fl_addr_q;
  assign o_data     = data_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: single read, round-robin order, wrap,
// timeout boundary, reset mid-transaction and address/request changes in flight.
module tb_flash_arbiter;

  localparam int N  = 4;
  localparam int AW = 21;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b1;
  logic [N-1:0]      i_req = '0;
  logic [N*AW-1:0]   i_addr;
  logic [N-1:0]      o_ack;
  logic [DW-1:0]     o_data;
  logic              o_err;
  logic              o_busy;
  logic              o_fl_start;
  logic [AW-1:0]     o_fl_addr;
  logic              i_fl_ack = 1'b0;
  logic [DW-1:0]     i_fl_data = '0;

  logic [AW-1:0]     addr [N];
  assign i_addr = {addr[3], addr[2], addr[1], addr[0]};

  int checks = 0;
  int errors = 0;

  // Results of the last run_txn call
  bit           r_ok;
  int           r_lat;
  int           r_starts;
  int           r_waits;
  logic [AW-1:0] r_addr;
  logic [N-1:0]  r_ack;
  logic [N-1:0]  r_ack_next;
  logic [DW-1:0] r_data;
  logic          r_err;
  logic          r_busy_next;

  flash_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .o_ack      (o_ack),
    .o_data     (o_data),
    .o_err      (o_err),
    .o_busy     (o_busy),
    .o_fl_start (o_fl_start),
    .o_fl_addr  (o_fl_addr),
    .i_fl_ack   (i_fl_ack),
    .i_fl_data  (i_fl_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst_n  = 1'b0;
    i_req    = '0;
    i_fl_ack = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
  endtask

  // Drives one request and a flash reader that acks on WAIT cycle ack_at (never if negative).
  task automatic run_txn(input logic [N-1:0] req, input bit keep_req, input int ack_at,
                         input logic [DW-1:0] word);
    r_ok = 1'b0; r_lat = 0; r_starts = 0; r_waits = 0;
    r_addr = '0; r_ack = '0; r_ack_next = '0; r_data = '0; r_err = 1'b0; r_busy_next = 1'b1;
    i_req = req;
    for (int i = 0; i < 20; i++) begin
      if (o_fl_start) break;
      tick();
      r_lat++;
    end
    if (!o_fl_start) return;
    r_addr   = o_fl_addr;
    r_starts = 1;
    if (!keep_req) i_req = '0;
    tick();
    for (int c = 0; c < TO + 5; c++) begin
      if (o_ack != '0) break;
      if (o_fl_start) r_starts++;
      if (o_busy) r_waits++;
      i_fl_ack  = (c == ack_at);
      i_fl_data = (c == ack_at) ? word : 32'hDEAD_BEEF;
      tick();
    end
    i_fl_ack = 1'b0;
    if (o_ack == '0) return;
    r_ack  = o_ack;
    r_data = o_data;
    r_err  = o_err;
    tick();
    r_ack_next  = o_ack;
    r_busy_next = o_busy;
    r_ok = 1'b1;
  endtask

  task automatic test_reset;
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if ({o_ack, o_data, o_err, o_busy, o_fl_start, o_fl_addr} !== '0) begin
      errors++; $display("FAIL reset_outputs got ack=%b data=%h err=%b busy=%b start=%b addr=%h exp all 0",
                         o_ack, o_data, o_err, o_busy, o_fl_start, o_fl_addr);
    end
    repeat (2) tick();
    i_rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (o_busy !== 1'b0 || o_fl_start !== 1'b0) begin
      errors++; $display("FAIL idle_no_req got busy=%b start=%b exp 0 0", o_busy, o_fl_start);
    end
  endtask

  task automatic test_basic;
    do_reset();
    run_txn(4'b0001, 1'b0, 2, 32'hCAFE_F00D);
    checks++; if (r_ok !== 1'b1) begin errors++; $display("FAIL basic_complete got %b exp 1", r_ok); end
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL basic_start_latency got %0d exp 1", r_lat); end
    checks++; if (r_addr !== 21'h00010) begin errors++; $display("FAIL basic_addr got %h exp 00010", r_addr); end
    checks++; if (r_starts !== 1) begin errors++; $display("FAIL basic_start_pulses got %0d exp 1", r_starts); end
    checks++; if (r_waits !== 3) begin errors++; $display("FAIL basic_wait_cycles got %0d exp 3", r_waits); end
    checks++; if (r_ack !== 4'b0001) begin errors++; $display("FAIL basic_ack got %b exp 0001", r_ack); end
    checks++; if (r_data !== 32'hCAFE_F00D || r_err !== 1'b0) begin
      errors++; $display("FAIL basic_data got %h err=%b exp cafef00d err=0", r_data, r_err);
    end
    checks++; if (r_ack_next !== 4'b0000 || r_busy_next !== 1'b0) begin
      errors++; $display("FAIL basic_after got ack=%b busy=%b exp 0000 0", r_ack_next, r_busy_next);
    end
    checks++; if (o_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL basic_data_hold got %h exp cafef00d", o_data); end
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      logic [N-1:0] exp_ack;
      exp_ack = 4'b0001 << (k % 4);
      run_txn(4'b1111, 1'b1, 0, 32'h1000_0000 + k);
      checks++; if (r_ack !== exp_ack || r_ack_next !== 4'b0000) begin
        errors++; $display("FAIL rr_grant_%0d got ack=%b next=%b exp %b 0000", k, r_ack, r_ack_next, exp_ack);
      end
      checks++; if (r_addr !== addr[k % 4] || r_data !== 32'h1000_0000 + k) begin
        errors++; $display("FAIL rr_addr_data_%0d got %h %h exp %h %h", k, r_addr, r_data, addr[k % 4], 32'h1000_0000 + k);
      end
      checks++; if (r_lat !== 1 || r_waits !== 1) begin
        errors++; $display("FAIL rr_period_%0d got lat=%0d waits=%0d exp 1 1", k, r_lat, r_waits);
      end
    end
    i_req = '0;
  endtask

  task automatic test_rr_wrap;
    do_reset();
    run_txn(4'b0010, 1'b0, 0, 32'h0000_0001);
    checks++; if (r_ack !== 4'b0010) begin errors++; $display("FAIL wrap_setup got %b exp 0010", r_ack); end
    run_txn(4'b0011, 1'b0, 0, 32'h0000_0002);
    checks++; if (r_ack !== 4'b0001 || r_addr !== addr[0]) begin
      errors++; $display("FAIL wrap_grant0 got ack=%b addr=%h exp 0001 %h", r_ack, r_addr, addr[0]);
    end
    run_txn(4'b0011, 1'b0, 0, 32'h0000_0003);
    checks++; if (r_ack !== 4'b0010) begin errors++; $display("FAIL wrap_ptr1 got %b exp 0010", r_ack); end
  endtask

  task automatic test_timeout;
    do_reset();
    run_txn(4'b0001, 1'b0, 0, 32'h5555_AAAA);
    checks++; if (r_data !== 32'h5555_AAAA) begin errors++; $display("FAIL to_setup got %h exp 5555aaaa", r_data); end
    run_txn(4'b0001, 1'b0, -1, 32'h0);
    checks++; if (r_ack !== 4'b0001 || r_err !== 1'b1 || r_data !== 32'h0) begin
      errors++; $display("FAIL to_abort got ack=%b err=%b data=%h exp 0001 1 0", r_ack, r_err, r_data);
    end
    checks++; if (r_waits !== TO) begin errors++; $display("FAIL to_wait_cycles got %0d exp %0d", r_waits, TO); end
    run_txn(4'b0001, 1'b0, TO - 1, 32'h600D_600D);
    checks++; if (r_ack !== 4'b0001 || r_err !== 1'b0 || r_data !== 32'h600D_600D) begin
      errors++; $display("FAIL to_edge_ack got ack=%b err=%b data=%h exp 0001 0 600d600d", r_ack, r_err, r_data);
    end
    checks++; if (r_waits !== TO) begin errors++; $display("FAIL to_edge_waits got %0d exp %0d", r_waits, TO); end
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    run_txn(4'b0010, 1'b0, 0, 32'h1234_5678);
    i_req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      if (o_fl_start) break;
      tick();
    end
    tick();
    tick();
    checks++; if (o_busy !== 1'b1 || o_fl_addr !== addr[2]) begin
      errors++; $display("FAIL rst_pre got busy=%b addr=%h exp 1 %h", o_busy, o_fl_addr, addr[2]);
    end
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_ack, o_data, o_err, o_busy, o_fl_start, o_fl_addr} !== '0) begin
      errors++; $display("FAIL rst_async got ack=%b data=%h err=%b busy=%b start=%b addr=%h exp all 0",
                         o_ack, o_data, o_err, o_busy, o_fl_start, o_fl_addr);
    end
    i_req = 4'b1111;
    i_fl_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (o_ack !== 4'b0000 || o_busy !== 1'b0) begin
        errors++; $display("FAIL rst_hold_%0d got ack=%b busy=%b exp 0000 0", i, o_ack, o_busy);
      end
    end
    i_fl_ack = 1'b0;
    i_rst_n  = 1'b1;
    run_txn(4'b1111, 1'b0, 0, 32'h0000_00AA);
    checks++; if (r_ack !== 4'b0001 || r_addr !== addr[0] || r_lat !== 1) begin
      errors++; $display("FAIL rst_regrant got ack=%b addr=%h lat=%0d exp 0001 %h 1", r_ack, r_addr, r_lat, addr[0]);
    end
  endtask

  task automatic test_inflight_changes;
    do_reset();
    addr[0] = 21'h00ABC;
    i_req   = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      if (o_fl_start) break;
      tick();
    end
    tick();
    i_req   = '0;
    addr[0] = 21'h1F000;
    tick();
    checks++; if (o_fl_addr !== 21'h00ABC) begin errors++; $display("FAIL hold_addr got %h exp 00abc", o_fl_addr); end
    i_fl_ack  = 1'b1;
    i_fl_data = 32'h0BAD_CAFE;
    tick();
    i_fl_ack = 1'b0;
    checks++; if (o_ack !== 4'b0001 || o_data !== 32'h0BAD_CAFE) begin
      errors++; $display("FAIL hold_ack got ack=%b data=%h exp 0001 0badcafe", o_ack, o_data);
    end
    tick();
    checks++; if (o_ack !== 4'b0000 || o_busy !== 1'b0) begin
      errors++; $display("FAIL hold_idle got ack=%b busy=%b exp 0000 0", o_ack, o_busy);
    end
    addr[0] = 21'h00010;
  endtask

  initial begin
    addr[0] = 21'h00010;
    addr[1] = 21'h00120;
    addr[2] = 21'h03450;
    addr[3] = 21'h1ABCD;
    test_reset();
    test_basic();
    test_round_robin();
    test_rr_wrap();
    test_timeout();
    test_reset_mid_wait();
    test_inflight_changes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter AW, default 21, meaning the flash word-address width.
REQ-003 The block SHALL have parameter DW, default 32, meaning the read data width.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before abort.
REQ-005 The block SHALL have port i_clk  input  1  single clock; all logic is rising-edge.
REQ-006 The block SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port i_req  input  N_REQ  per-requester read request level.
REQ-008 The block SHALL have port i_addr  input  N_REQ*AW  packed per-requester address; requester k occupies bits [k*AW +: AW].
REQ-009 The block SHALL have port o_ack  output  N_REQ  one-hot, one-cycle completion pulse.
REQ-010 The block SHALL have port o_data  output  DW  read data, valid while o_ack is nonzero.
REQ-011 The block SHALL have port o_err  output  1  timeout flag, valid while o_ack is nonzero.
REQ-012 The block SHALL have port o_busy  output  1  high whenever the state is not IDLE.
REQ-013 The block SHALL have port o_fl_start  output  1  one-cycle start pulse to the flash reader.
REQ-014 The block SHALL have port o_fl_addr  output  AW  address to the flash reader.
REQ-015 The block SHALL have port i_fl_ack  input  1  one-cycle data-valid pulse from the flash reader.
REQ-016 The block SHALL have port i_fl_data  input  DW  flash reader data, sampled when i_fl_ack is high.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, and all outputs SHALL be driven from registers or decoded from the state register only.
REQ-018 In IDLE with i_req nonzero, the block SHALL select the winner by round-robin starting at rr_ptr, ascending with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
REQ-019 On selection, the block SHALL latch the winner index and its address into o_fl_addr, then go to ISSUE.
REQ-020 In IDLE with i_req zero, the block SHALL remain in IDLE.
REQ-021 In ISSUE, o_fl_start SHALL be 1 for exactly that cycle, the timer SHALL clear to 0, and the FSM SHALL go to WAIT.
REQ-022 In WAIT with i_fl_ack=1, the block SHALL latch i_fl_data into o_data, clear the error, and go to DONE.
REQ-023 In WAIT with i_fl_ack=0, the timer SHALL increment; when the timer equals TIMEOUT, the block SHALL set the error flag, set o_data to 0, and go to DONE.
REQ-024 If i_fl_ack=1 on the same cycle the timer reaches TIMEOUT, the ack SHALL win and no error SHALL be flagged.
REQ-025 In DONE, o_ack[winner] SHALL be 1 for exactly one cycle and o_err SHALL reflect the flag.
REQ-026 In DONE, rr_ptr SHALL update to (winner+1) mod N_REQ, and the FSM SHALL return to IDLE.
REQ-027 o_fl_addr and o_data SHALL hold their values outside ISSUE and DONE until the next latch.
REQ-028 i_fl_ack SHALL be ignored in IDLE, ISSUE and DONE.
REQ-029 If the winner drops i_req mid-transaction, the transaction SHALL complete and o_ack SHALL still pulse.
REQ-030 i_addr changes after selection SHALL have no effect on the transaction in flight.
REQ-031 Latency SHALL be as follows: a request sampled in IDLE at edge t gives o_fl_start high in cycle t+1; i_fl_ack in WAIT at edge u gives o_ack in cycle u+1; the minimum request-to-request period is 4 cycles.
REQ-032 The timer SHALL be wide enough for TIMEOUT and SHALL never wrap.

Reset
REQ-033 When i_rst_n=0, the block SHALL asynchronously force: state IDLE, rr_ptr 0, timer 0, o_ack 0, o_data 0, o_err 0, o_busy 0, o_fl_start 0, o_fl_addr 0.
REQ-034 Reset during ISSUE or WAIT SHALL abandon the transaction with no o_ack, and the block SHALL arbitrate from rr_ptr=0 after release.
REQ-035 Reset release SHALL take effect at the first rising edge after i_rst_n rises.

Verification
REQ-036 The bench SHALL apply i_req=0001, addr0=0x00010, and flash acks 3 cycles after start, and SHALL check o_fl_addr=0x00010, a one-cycle o_fl_start, o_ack=0001, and o_data equal to the flash word with o_err=0.
REQ-037 The bench SHALL hold i_req=1111 for 8 transactions and SHALL check the grant order 0,1,2,3,0,1,2,3, each with exactly one o_ack pulse.
REQ-038 With rr_ptr=2 and i_req=0011, the bench SHALL check that requester 0 is granted and rr_ptr becomes 1.
REQ-039 The bench SHALL never ack the flash and SHALL check o_ack after TIMEOUT WAIT cycles with o_err=1 and o_data=0; with the ack arriving exactly on the TIMEOUT cycle, it SHALL check o_err=0.
REQ-040 The bench SHALL assert reset mid-WAIT and SHALL check that all outputs go to 0 immediately, no o_ack follows, and the next grant goes to requester 0.
REQ-041 The bench SHALL drop i_req and change addr0 after ISSUE, and SHALL check that the original address is still used and o_ack still pulses.
